// File: rtl/pe_vector_feeder_if.sv
// Feeder-to-PE operand/result channel; the feeder drives operands, the PE returns step_fin/result.
interface pe_vector_feeder_if #(
    parameter int unsigned DATA_W = 32
);
    logic              active;
    logic              vec_fin;
    logic [31:0]       length;
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
    logic              step_fin;
    logic [DATA_W-1:0] result;

    modport master (
        output active, vec_fin, length, left, right,
        input  step_fin, result
    );

    modport slave (
        input  active, vec_fin, length, left, right,
        output step_fin, result
    );
endinterface

// File: rtl/pe_vector_feeder.sv
// Dot-product operand sequencer and result collector for a single MAC PE.
// Optional PE_FEEDER_STALL_CNT_EN adds stall_cnt_o, counting PE back-pressure cycles per command.
module pe_vector_feeder #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_a_i,
    input  logic [ADDR_W-1:0] base_b_i,
    input  logic [31:0]       length_i,
    output logic              busy_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic              a_en_o,
    output logic [ADDR_W-1:0] a_addr_o,
    input  logic [DATA_W-1:0] a_rdata_i,
    output logic              b_en_o,
    output logic [ADDR_W-1:0] b_addr_o,
    input  logic [DATA_W-1:0] b_rdata_i,
    pe_vector_feeder_if.master pe
`ifdef PE_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);

    typedef enum logic [2:0] {StFlush, StIdle, StStream, StDrain, StResult} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d;
    logic [ADDR_W-1:0] base_b_q, base_b_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       idx_q, idx_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_last_q, rd_last_d;
    logic              act_q, act_d;
    logic              fin_q, fin_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic [DATA_W-1:0] res_q, res_d;

    logic stall, issue, last_rd, capture;

    // The PE holding back its step freezes every pipeline stage, including read issue.
    assign stall   = act_q & ~pe.step_fin;
    assign issue   = (state_q == StStream) & ~stall;
    assign last_rd = (idx_q == len_q - 32'd1);
    assign capture = act_q & fin_q & pe.step_fin;

    always_comb begin
        state_d  = state_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        len_d    = len_q;
        idx_d    = idx_q;
        res_d    = res_q;
        unique case (state_q)
            StFlush: state_d = StIdle;
            StIdle: begin
                if (start_i) begin
                    base_a_d = base_a_i;
                    base_b_d = base_b_i;
                    len_d    = length_i;
                    idx_d    = '0;
                    if (length_i == 32'd0) begin
                        res_d   = '0;
                        state_d = StResult;
                    end else begin
                        state_d = StStream;
                    end
                end
            end
            StStream: begin
                if (issue) begin
                    idx_d = idx_q + 32'd1;
                    if (last_rd) state_d = StDrain;
                end
            end
            StDrain: begin
                if (capture) begin
                    res_d   = pe.result;
                    state_d = StResult;
                end
            end
            StResult: begin
                if (res_ready_i) state_d = StIdle;
            end
            default: state_d = StFlush;
        endcase
    end

    // Read stage (data arriving on rdata) feeding the PE operand stage.
    always_comb begin
        rd_vld_d  = rd_vld_q;
        rd_last_d = rd_last_q;
        act_d     = act_q;
        fin_d     = fin_q;
        left_d    = left_q;
        right_d   = right_q;
        if (!stall) begin
            rd_vld_d  = issue;
            rd_last_d = issue & last_rd;
            act_d     = rd_vld_q;
            fin_d     = rd_vld_q & rd_last_q;
            left_d    = rd_vld_q ? a_rdata_i : '0;
            right_d   = rd_vld_q ? b_rdata_i : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFlush;
            base_a_q  <= '0;
            base_b_q  <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            act_q     <= 1'b0;
            fin_q     <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            base_a_q  <= base_a_d;
            base_b_q  <= base_b_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
            act_q     <= act_d;
            fin_q     <= fin_d;
            left_q    <= left_d;
            right_q   <= right_d;
            res_q     <= res_d;
        end
    end

`ifdef PE_FEEDER_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((state_q == StIdle) && start_i) begin
            stall_cnt_q <= '0;
        end else if (stall && ((state_q == StStream) || (state_q == StDrain))) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    assign busy_o      = (state_q != StIdle);
    assign res_valid_o = (state_q == StResult);
    assign res_data_o  = res_q;
    assign a_en_o      = issue;
    assign b_en_o      = issue;
    assign a_addr_o    = base_a_q + idx_q[ADDR_W-1:0];
    assign b_addr_o    = base_b_q + idx_q[ADDR_W-1:0];

    // FLUSH presents vec_fin without a pair so the PE clears its accumulator.
    assign pe.active  = act_q;
    assign pe.vec_fin = fin_q | (state_q == StFlush);
    assign pe.length  = len_q;
    assign pe.left    = left_q;
    assign pe.right   = right_q;

endmodule

// File: tb/tb_pe_vector_feeder.sv
// Directed bench for pe_vector_feeder with behavioural operand memories and a MAC PE model.
module tb_pe_vector_feeder;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst, start, res_ready, busy, res_valid;
    logic [AW-1:0] base_a, base_b, a_addr, b_addr;
    logic [31:0]   length;
    logic [DW-1:0] res_data, a_rdata, b_rdata;
    logic          a_en, b_en, step_fin;
    logic [DW-1:0] acc = '0;
`ifdef PE_FEEDER_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    logic [DW-1:0] mem_a [1024];
    logic [DW-1:0] mem_b [1024];

    always #5 clk = ~clk;

    pe_vector_feeder_if #(.DATA_W(DW)) pe_bus ();

    pe_vector_feeder #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .base_a_i    (base_a),
        .base_b_i    (base_b),
        .length_i    (length),
        .busy_o      (busy),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .a_en_o      (a_en),
        .a_addr_o    (a_addr),
        .a_rdata_i   (a_rdata),
        .b_en_o      (b_en),
        .b_addr_o    (b_addr),
        .b_rdata_i   (b_rdata),
        .pe          (pe_bus)
`ifdef PE_FEEDER_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    // PE model: accumulator cleared by vec_fin, result is combinational acc + left*right.
    assign pe_bus.step_fin = step_fin;
    assign pe_bus.result   = acc + pe_bus.left * pe_bus.right;

    always @(posedge clk) begin
        if (pe_bus.vec_fin && !pe_bus.active) acc <= '0;
        else if (pe_bus.active && step_fin) acc <= pe_bus.vec_fin ? '0 : acc + pe_bus.left * pe_bus.right;
    end

    always @(posedge clk) begin
        if (a_en) a_rdata <= mem_a[a_addr];
        if (b_en) b_rdata <= mem_b[b_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int            first_act, fin_cyc, res_cyc, n_rd, n_act, hold_n;
    int            stall_at, stall_len, ready_delay;
    logic [DW-1:0] fin_l, fin_r, res_val;
    logic [AW-1:0] addr_log [64];
    logic [DW-1:0] left_log [64];
    logic [DW-1:0] right_log [64];

    // Issues one command in the current cycle (cycle 0) and runs until the result handshake.
    task automatic run_cmd(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                           input logic [31:0] len, input logic [31:0] exp_res);
        logic hs, timed_out;
        first_act = -1; fin_cyc = -1; res_cyc = -1; n_rd = 0; n_act = 0; hold_n = 0;
        fin_l = '0; fin_r = '0; res_val = '0; timed_out = 1'b1;
        base_a = ba; base_b = bb; length = len; start = 1'b1;
        res_ready = (ready_delay == 0);
        step_fin = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c < 64) begin
                left_log[c]  = pe_bus.left;
                right_log[c] = pe_bus.right;
            end
            if (pe_bus.active) n_act++;
            if (pe_bus.active && first_act < 0) first_act = c;
            if (pe_bus.active && pe_bus.vec_fin) begin
                fin_cyc = c; fin_l = pe_bus.left; fin_r = pe_bus.right;
            end
            if (a_en) begin
                if (n_rd < 64) addr_log[n_rd] = a_addr;
                n_rd++;
            end
            if (res_valid) begin
                if (res_cyc < 0) begin
                    res_cyc = c; res_val = res_data;
                end else begin
                    check("res_hold", res_data, exp_res);
                end
                hold_n++;
            end
            hs = res_valid && res_ready;
            tick();
            if (hs) begin
                start = 1'b0; res_ready = 1'b0; step_fin = 1'b1; timed_out = 1'b0;
                break;
            end
            start     = (ready_delay > 0) && res_valid && (hold_n == 2 || hold_n == ready_delay);
            res_ready = (hold_n >= ready_delay);
            step_fin  = !((c + 1) >= stall_at && (c + 1) < stall_at + stall_len);
        end
        if (timed_out) check("timeout", 32'd1, 32'd0);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_valid"}, {31'd0, res_valid}, 32'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; res_ready = 1'b0; step_fin = 1'b1;
        base_a = '0; base_b = '0; length = '0;
        stall_at = 1000; stall_len = 0; ready_delay = 0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = i + 1;
            mem_b[i] = i + 5;
        end
        mem_a[1022] = 2;  mem_a[1023] = 3;
        mem_b[100] = 10;  mem_b[101] = 20; mem_b[102] = 30; mem_b[103] = 40;
        mem_a[10] = 3;    mem_a[11] = 5;   mem_a[12] = 7;
        mem_b[20] = 2;    mem_b[21] = 4;   mem_b[22] = 6;
        mem_a[50] = 3;    mem_b[60] = 4;

        // Reset release: one FLUSH cycle, then IDLE
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("flush_fin", {31'd0, pe_bus.vec_fin}, 32'd1);
        check("flush_act", {31'd0, pe_bus.active}, 32'd0);
        check("flush_aen", {31'd0, a_en}, 32'd0);
        check("flush_valid", {31'd0, res_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("idle_fin", {31'd0, pe_bus.vec_fin}, 32'd0);
        tick();
        idle_check("idle");

        // [1,2,3,4].[5,6,7,8] = 70
        run_cmd(10'd0, 10'd0, 32'd4, 32'd70);
        check("dot_res", res_val, 32'd70);
        check("dot_res_cyc", res_cyc, 32'd7);
        check("dot_first_act", first_act, 32'd3);
        check("dot_fin_cyc", fin_cyc, 32'd6);
        check("dot_fin_l", fin_l, 32'd4);
        check("dot_fin_r", fin_r, 32'd8);
        check("dot_nrd", n_rd, 32'd4);
        check("dot_nact", n_act, 32'd4);
        idle_check("dot_after");

        // Empty vector
        run_cmd(10'd5, 10'd5, 32'd0, 32'd0);
        check("n0_res", res_val, 32'd0);
        check("n0_res_cyc", res_cyc, 32'd1);
        check("n0_nrd", n_rd, 32'd0);
        check("n0_nact", n_act, 32'd0);
        idle_check("n0_after");

        // Address wrap: 2*10 + 3*20 + 1*30 + 2*40 = 190
        run_cmd(10'd1022, 10'd100, 32'd4, 32'd190);
        check("wrap_res", res_val, 32'd190);
        check("wrap_addr0", addr_log[0], 32'd1022);
        check("wrap_addr1", addr_log[1], 32'd1023);
        check("wrap_addr2", addr_log[2], 32'd0);
        check("wrap_addr3", addr_log[3], 32'd1);
        idle_check("wrap_after");

        // Stall on element 1 for two cycles: 3*2 + 5*4 + 7*6 = 68
        stall_at = 4; stall_len = 2;
        run_cmd(10'd10, 10'd20, 32'd3, 32'd68);
        stall_at = 1000; stall_len = 0;
        check("stall_res", res_val, 32'd68);
        check("stall_res_cyc", res_cyc, 32'd8);
        check("stall_fin_cyc", fin_cyc, 32'd7);
        check("stall_l4", left_log[4], 32'd5);
        check("stall_l5", left_log[5], 32'd5);
        check("stall_r5", right_log[5], 32'd4);
        check("stall_l6", left_log[6], 32'd5);
        check("stall_nrd", n_rd, 32'd3);
`ifdef PE_FEEDER_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 32'd2);
`endif
        idle_check("stall_after");

        // Back-pressure on the result with start pulses: 1*5 + 2*6 = 17
        ready_delay = 5;
        run_cmd(10'd0, 10'd0, 32'd2, 32'd17);
        ready_delay = 0;
        check("hold_res", res_val, 32'd17);
        check("hold_res_cyc", res_cyc, 32'd5);
        check("hold_cycles", hold_n, 32'd6);
        idle_check("hold_after");

        // Reset in the middle of STREAM
        base_a = '0; base_b = '0; length = 32'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        check("mid_aen", {31'd0, a_en}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_fin", {31'd0, pe_bus.vec_fin}, 32'd1);
        check("rst_act", {31'd0, pe_bus.active}, 32'd0);
        check("rst_aen", {31'd0, a_en}, 32'd0);
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        tick();
        idle_check("rst_idle");

        run_cmd(10'd50, 10'd60, 32'd1, 32'd12);
        check("n1_res", res_val, 32'd12);
        check("n1_fin_cyc", fin_cyc, 32'd3);
        check("n1_res_cyc", res_cyc, 32'd4);
        idle_check("n1_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
